neuron_feeder: RTL and testbench

- Initiator-side driver for the Neuron start_/end_ interface.
- Collects N_INPUTS samples from an upstream valid/ready stream into a packed input buffer and pulses nrn_start_.
- Waits for the neuron's end_ pulse, captures its out bit and presents it downstream on a valid/ready result port.
- A watchdog flags a neuron that never completes, so a layer sequencer can chain feeder+neuron pairs without hanging.

---
 rtl/neuron_feeder.sv | 145 ++++++++++++++
 tb/tb_neuron_feeder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_feeder.sv
// Initiator-side driver for the Neuron start_/end_ handshake: gathers N_INPUTS samples,
// fires the neuron, waits (with a watchdog) for its answer and hands it downstream.
module neuron_feeder #(
    parameter int N_INPUTS = 9,
    parameter int IN_W     = 9,
    parameter int TIMEOUT  = 255,
    parameter int TO_W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IN_W-1:0]          in_data,
    output logic                     nrn_start_,
    output logic [N_INPUTS*IN_W-1:0] nrn_inputs,
    input  logic                     nrn_out,
    input  logic                     nrn_end_,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic                     res_data,
    output logic                     res_timeout,
    output logic                     busy
);

    localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(N_INPUTS - 1);
    localparam logic [TO_W-1:0]  WDOG_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_FIRE,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_count;
    logic [TO_W-1:0]  r_wdog;
    logic [IN_W-1:0]  r_elem [N_INPUTS];
    logic             r_res_data;
    logic             r_res_timeout;

    logic             w_accept;
    logic             w_last;
    logic             w_to_hit;

    assign w_last   = (r_count == LAST_IDX);
    assign w_to_hit = (r_wdog == WDOG_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        nrn_start_   = 1'b0;
        busy         = 1'b0;
        res_valid    = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_LOAD: begin
                // Held low while reset is applied so upstream never sees a dropped accept.
                in_ready = ~rst;
                w_accept = in_valid & ~rst;
                if (w_accept && w_last) begin
                    w_state_next = S_FIRE;
                end
            end
            S_FIRE: begin
                nrn_start_   = 1'b1;
                busy         = 1'b1;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (nrn_end_ || w_to_hit) begin
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_state_next = S_LOAD;
                end
            end
            default: w_state_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count       <= '0;
            r_wdog        <= '0;
            r_res_data    <= 1'b0;
            r_res_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        r_count <= w_last ? '0 : r_count + 1'b1;
                    end
                end
                S_FIRE: begin
                    r_wdog <= '0;
                end
                S_WAIT: begin
                    // A real completion wins over the watchdog firing in the same cycle.
                    if (nrn_end_) begin
                        r_res_data    <= nrn_out;
                        r_res_timeout <= 1'b0;
                    end else if (w_to_hit) begin
                        r_res_data    <= 1'b0;
                        r_res_timeout <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_elem
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_elem[gi] <= '0;
                end else if (w_accept && (r_count == CNT_W'(gi))) begin
                    r_elem[gi] <= in_data;
                end
            end
            assign nrn_inputs[gi*IN_W +: IN_W] = r_elem[gi];
        end
    endgenerate

    assign res_data    = r_res_data;
    assign res_timeout = r_res_timeout;

endmodule

// File: tb/tb_neuron_feeder.sv
// Directed + randomized bench for neuron_feeder; expectations come from the
// timing/ordering rules of the feeder, tracked with a simple buffer model.
module tb_neuron_feeder;

    localparam int N_INPUTS = 9;
    localparam int IN_W     = 9;
    localparam int TIMEOUT  = 255;
    localparam int TO_W     = 8;
    localparam int BUF_W    = N_INPUTS * IN_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             nrn_start_;
    logic [BUF_W-1:0] nrn_inputs;
    logic             nrn_out;
    logic             nrn_end_;
    logic             res_valid;
    logic             res_ready;
    logic             res_data;
    logic             res_timeout;
    logic             busy;

    int               checks = 0;
    int               errors = 0;
    logic [BUF_W-1:0] exp_buf;
    int               wr_idx;
    logic             exp_data;
    logic             exp_to;

    neuron_feeder #(
        .N_INPUTS(N_INPUTS), .IN_W(IN_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .nrn_start_(nrn_start_), .nrn_inputs(nrn_inputs),
        .nrn_out(nrn_out), .nrn_end_(nrn_end_),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_timeout(res_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic chkv(input string tag, input logic [BUF_W-1:0] obs, input logic [BUF_W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic reset_checks(input string tag);
        chk1({tag, "_in_ready"}, in_ready, 1'b1);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_start"}, nrn_start_, 1'b0);
        chk1({tag, "_res_valid"}, res_valid, 1'b0);
        chk1({tag, "_res_data"}, res_data, 1'b0);
        chk1({tag, "_res_timeout"}, res_timeout, 1'b0);
        chkv({tag, "_buffer"}, nrn_inputs, exp_buf);
    endtask

    // base < 0 selects random sample values; gap_mode 0 none, 1 alternate, 2 random
    task automatic load(input int n, input int base, input int gap_mode);
        logic [IN_W-1:0] v;
        bit fired;
        fired = 0;
        for (int k = 0; k < n; k++) begin
            if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 1) == 1)) begin
                in_valid = 1'b0;
                in_data  = IN_W'($urandom);
                chk1("gap_ready", in_ready, 1'b1);
                tick();
            end
            v        = (base < 0) ? IN_W'($urandom) : IN_W'(base + k);
            in_valid = 1'b1;
            in_data  = v;
            chk1("load_ready", in_ready, 1'b1);
            chk1("load_no_start", nrn_start_, 1'b0);
            tick();
            exp_buf[wr_idx*IN_W +: IN_W] = v;
            wr_idx++;
            if (wr_idx == N_INPUTS) begin
                wr_idx = 0;
                fired  = 1;
            end
        end
        in_valid = 1'b0;
        chkv("load_buffer", nrn_inputs, exp_buf);
        if (fired) begin
            chk1("fire_start", nrn_start_, 1'b1);
            chk1("fire_busy", busy, 1'b1);
            chk1("fire_in_ready", in_ready, 1'b0);
        end
    endtask

    // Called in the FIRE cycle. end_at = WAIT cycle (1-based) with nrn_end_, 0 = never.
    task automatic wait_result(input int end_at, input logic out_bit, input bit fire_end);
        int n;
        bool_in_range: begin end
        exp_to   = !(end_at >= 1 && end_at <= TIMEOUT);
        exp_data = exp_to ? 1'b0 : out_bit;
        n        = exp_to ? TIMEOUT : end_at;
        if (fire_end) begin
            nrn_end_ = 1'b1;
            nrn_out  = 1'b1;
        end
        for (int c = 1; c <= n; c++) begin
            tick();
            nrn_end_ = 1'b0;
            nrn_out  = 1'($urandom);
            in_valid = 1'($urandom_range(0, 1));
            in_data  = IN_W'($urandom);
            if (c == 1) chk1("wait_start_low", nrn_start_, 1'b0);
            chk1("wait_busy", busy, 1'b1);
            chk1("wait_no_valid", res_valid, 1'b0);
            if (c == end_at) begin
                nrn_end_ = 1'b1;
                nrn_out  = out_bit;
            end
        end
        tick();
        nrn_end_ = 1'b0;
        in_valid = 1'b0;
        chk1("hold_valid", res_valid, 1'b1);
        chk1("hold_data", res_data, exp_data);
        chk1("hold_timeout", res_timeout, exp_to);
        chk1("hold_busy", busy, 1'b0);
        chk1("hold_in_ready", in_ready, 1'b0);
        chkv("hold_buffer", nrn_inputs, exp_buf);
    endtask

    task automatic release_result(input int hold);
        for (int i = 0; i < hold; i++) begin
            res_ready = 1'b0;
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = IN_W'($urandom);
            tick();
            chk1("stall_valid", res_valid, 1'b1);
            chk1("stall_data", res_data, exp_data);
            chk1("stall_timeout", res_timeout, exp_to);
            chk1("stall_in_ready", in_ready, 1'b0);
            chkv("stall_buffer", nrn_inputs, exp_buf);
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        chk1("ack_valid", res_valid, 1'b1);
        tick();
        res_ready = 1'b0;
        chk1("after_ack_valid", res_valid, 1'b0);
        chk1("after_ack_in_ready", in_ready, 1'b1);
        chkv("after_ack_buffer", nrn_inputs, exp_buf);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        nrn_out   = 1'b0;
        nrn_end_  = 1'b0;
        res_ready = 1'b0;
        exp_buf   = '0;
        wr_idx    = 0;
        tick();
        tick();
        chk1("rst_cycle_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        #1;
        reset_checks("reset");

        // Back-to-back stream 1..9, neuron answers 1 five cycles after start.
        load(N_INPUTS, 1, 0);
        wait_result(5, 1'b1, 0);
        release_result(0);

        // Same, downstream stalls for 10 cycles.
        load(N_INPUTS, 1, 0);
        wait_result(5, 1'b1, 0);
        release_result(10);

        // Neuron never answers: watchdog abort.
        load(N_INPUTS, -1, 0);
        wait_result(0, 1'b1, 0);
        release_result(0);

        // Completion exactly on the last watchdog cycle wins over the abort.
        load(N_INPUTS, -1, 0);
        wait_result(TIMEOUT, 1'b1, 0);
        release_result(1);

        // Reset while waiting on the neuron.
        load(N_INPUTS, -1, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk1("pre_rst_busy", busy, 1'b1);
        end
        rst = 1'b1;
        #1;
        chk1("rst_wait_in_ready", in_ready, 1'b0);
        tick();
        rst     = 1'b0;
        exp_buf = '0;
        wr_idx  = 0;
        #1;
        reset_checks("rst_wait");

        // Reset after 4 of 9 samples, with a sample offered during the reset cycle.
        load(4, 30, 0);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = IN_W'(99);
        #1;
        chk1("rst_load_in_ready", in_ready, 1'b0);
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        exp_buf  = '0;
        wr_idx   = 0;
        #1;
        reset_checks("rst_load");
        load(N_INPUTS, 10, 0);
        wait_result(3, 1'b1, 0);
        release_result(0);

        // Gapped upstream, plus a spurious end_ during FIRE.
        load(N_INPUTS, 1, 1);
        wait_result(7, 1'b0, 1);
        release_result(0);

        // Randomized transactions.
        for (int t = 0; t < 8; t++) begin
            int e;
            e = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 20));
            load(N_INPUTS, -1, 2);
            wait_result(e, 1'($urandom), 1'($urandom));
            release_result(int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
